// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for a word-wide data memory.
// Handles byte/half/word loads and stores with big-endian lane numbering
// (offset 0 = bits[31:24]). Sub-word stores are done as read-modify-write.
// Optional feature: define BOUNDS_CHECK_EN to reject word indices >= SIZE
// as errors before any memory access.

// One byte lane of the read-modify-write merge.
module lsu_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             memory_read,
  output logic             memory_write,
  output logic [WIDTH-1:0] memory_address,
  output logic [WIDTH-1:0] memory_data_write,
  input  logic [WIDTH-1:0] memory_data_read
);
  localparam int NUM_LANES = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state, state_nxt;

  // Request fields latched at the accept edge.
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;   // only sub-word stores need the data after accept
  logic        err_q;

  logic             accept;
  logic             misalign;
  logic             oob;
  logic             req_err;
  logic             word_store;
  logic [WIDTH-1:0] word_idx;

  assign accept     = req_valid && req_ready;
  assign word_store = req_write && (req_size == 2'b10);
  assign word_idx   = {2'b00, req_addr[WIDTH-1:2]};

  // Alignment / legality of the incoming request.
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

`ifdef BOUNDS_CHECK_EN
  assign oob = (word_idx >= WIDTH'(SIZE));
`else
  assign oob = 1'b0;
`endif

  assign req_err = misalign || oob;

  // ---------------- read-modify-write merge ----------------
  logic [NUM_LANES-1:0]       lane_en;
  logic [WIDTH-1:0]           rep;
  logic [WIDTH-1:0]           merged;

  // Replicate store data so each lane can pick its byte from its own slot.
  assign rep = (size_q == 2'b00) ? {NUM_LANES{wdata_q[7:0]}} : {(NUM_LANES/2){wdata_q[15:0]}};

  // Lane enables: lane i holds big-endian offset (NUM_LANES-1-i).
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (size_q == 2'b00)
        lane_en[i] = (off_q == 2'(NUM_LANES - 1 - i));
      else if (size_q == 2'b01)
        lane_en[i] = ((i >= 2) == !off_q[1]);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane u_lane (
      .old_byte (memory_data_read[8*g +: 8]),
      .new_byte (rep[8*g +: 8]),
      .en       (lane_en[g]),
      .merged   (merged[8*g +: 8])
    );
  end

  // ---------------- load extraction ----------------
  logic [4:0]       shamt;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] ext;

  assign shamt  = {~off_q, 3'b000};  // (3 - offset) * 8
  assign byte_v = 8'(memory_data_read >> shamt);
  assign half_v = off_q[1] ? memory_data_read[15:0] : memory_data_read[31:16];

  // Select the loaded lane and sign/zero-extend it.
  always_comb begin
    ext = memory_data_read;
    case (size_q)
      2'b00:   ext = sgn_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      2'b01:   ext = sgn_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: ext = memory_data_read;
    endcase
  end

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and strobes; strobes decode state so reset drops them at once.
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)         state_nxt = RESP;
          else if (word_store) state_nxt = WR;
          else                 state_nxt = RD;
        end
      end
      RD: begin
        memory_read = 1'b1;
        state_nxt   = wr_q ? WR : RESP;
      end
      WR: begin
        memory_write = 1'b1;
        state_nxt    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, memory address/data and load result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q              <= 1'b0;
      size_q            <= 2'b00;
      sgn_q             <= 1'b0;
      off_q             <= 2'b00;
      wdata_q           <= '0;
      err_q             <= 1'b0;
      resp_rdata        <= '0;
      memory_address    <= '0;
      memory_data_write <= '0;
    end else begin
      if (accept) begin
        wr_q       <= req_write;
        size_q     <= req_size;
        sgn_q      <= req_signed;
        off_q      <= req_addr[1:0];
        wdata_q    <= req_wdata[15:0];
        err_q      <= req_err;
        resp_rdata <= '0;  // stores and errors report zero
        // Errors never touch the memory port, so address/data keep their values.
        if (!req_err) begin
          memory_address <= word_idx;
          if (word_store) memory_data_write <= req_wdata;
        end
      end
      if (state == RD) begin
        if (wr_q) memory_data_write <= merged;
        else      resp_rdata        <= ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a
// scoreboard queue of expected responses.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        memory_read, memory_write;
  logic [31:0] memory_address, memory_data_write, memory_data_read;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t exp_q[$];

  load_store_unit #(.WIDTH(32), .SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .memory_read(memory_read), .memory_write(memory_write),
    .memory_address(memory_address), .memory_data_write(memory_data_write),
    .memory_data_read(memory_data_read)
  );

  always #5 clk = ~clk;

  assign memory_data_read = mem[memory_address[9:0]];

  always @(posedge clk)
    if (memory_write) mem[memory_address[9:0]] <= memory_data_write;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, queue its expected response, then wait (bounded) for it.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic e, input logic [31:0] rd_exp,
                        input int lat, input int nrd, input int nwr);
    exp_t x, y;
    int cyc, nr, nw, both, guard;
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    x.err = e; x.rdata = rd_exp; x.lat = lat; x.nrd = nrd; x.nwr = nwr;
    exp_q.push_back(x);
    @(posedge clk);  // accept edge
    @(negedge clk);
    req_valid = 1'b0;
    // scramble request fields: the unit must ignore them while busy
    req_write = ~w; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; got = 0; nr = 0; nw = 0; both = 0;
    while (!got && cyc <= 8) begin
      nr += int'(memory_read);
      nw += int'(memory_write);
      both += int'(memory_read && memory_write);
      if (resp_valid) got = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    y = exp_q.pop_front();
    check({tag, ".resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, ".latency"}, 32'(cyc), 32'(y.lat));
      check({tag, ".err"}, 32'(resp_err), 32'(y.err));
      check({tag, ".rdata"}, resp_rdata, y.rdata);
      check({tag, ".rd_cycles"}, 32'(nr), 32'(y.nrd));
      check({tag, ".wr_cycles"}, 32'(nw), 32'(y.nwr));
      check({tag, ".strobe_excl"}, 32'(both), 32'd0);
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFEF00D;
    mem[8] = 32'h11111111;

    // reset state
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.mem_read", 32'(memory_read), 32'd0);
    check("rst.mem_write", 32'(memory_write), 32'd0);
    check("rst.mem_addr", memory_address, 32'd0);
    check("rst.mem_wdata", memory_data_write, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // word store then word load
    do_req("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1);
    check("mem4_after_st_w", mem[4], 32'hDEADBEEF);
    do_req("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2, 1, 0);

    // sub-word loads
    do_req("ld_bs", 0, 2'b00, 1, 32'h12, 32'h0, 0, 32'hFFFFFFBE, 2, 1, 0);
    do_req("ld_hu", 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h0000DEAD, 2, 1, 0);
    do_req("ld_hs", 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFFBEEF, 2, 1, 0);
    do_req("ld_bu", 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h000000EF, 2, 1, 0);
    do_req("ld_bs0", 0, 2'b00, 1, 32'h10, 32'h0, 0, 32'hFFFFFFDE, 2, 1, 0);

    // sub-word stores (read-modify-write)
    do_req("st_b", 1, 2'b00, 0, 32'h11, 32'hFFFFFF55, 0, 32'h0, 3, 1, 1);
    check("mem4_after_st_b", mem[4], 32'hDE55BEEF);
    check("addr_hold", memory_address, 32'd4);
    do_req("st_h", 1, 2'b01, 0, 32'h12, 32'hAAAA1234, 0, 32'h0, 3, 1, 1);
    check("mem4_after_st_h", mem[4], 32'hDE551234);

    // errors: no strobes, memory untouched
    do_req("err_ld_h", 0, 2'b01, 0, 32'h13, 32'h0, 1, 32'h0, 1, 0, 0);
    do_req("err_st_w", 1, 2'b10, 0, 32'h02, 32'h77777777, 1, 32'h0, 1, 0, 0);
    do_req("err_sz3", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 1, 0, 0);
    check("mem0_after_err", mem[0], 32'hCAFEF00D);
    check("mem4_after_err", mem[4], 32'hDE551234);

    // reset during the WR cycle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid.in_wr", 32'(memory_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.mem_write", 32'(memory_write), 32'd0);
    check("rstmid.req_ready", 32'(req_ready), 32'd1);
    check("rstmid.mem_addr", memory_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    check("rstmid.no_resp", 32'(seen), 32'd0);
    check("rstmid.mem8", mem[8], 32'h11111111);

    // out-of-range word index
`ifdef BOUNDS_CHECK_EN
    do_req("oob", 0, 2'b10, 0, 32'h1000, 32'h0, 1, 32'h0, 1, 0, 0);
`else
    // index 0x400 aliases word 0 of the 1024-word bench memory
    do_req("oob", 0, 2'b10, 0, 32'h1000, 32'h0, 0, 32'hCAFEF00D, 2, 1, 0);
    check("oob.mem_addr", memory_address, 32'h400);
`endif

    // back-to-back after a reset-aborted op still works
    do_req("ld_after", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDE551234, 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
